// File: rtl/fpu_addsub_operand_stage.sv
// fpu_addsub_operand_stage: registered binary32 operand unpack with 2-entry skid buffer.
// Define FPU_ADDSUB_DAZ_EN to flush subnormal inputs to signed zero and add daz_o.
module fpu_addsub_operand_stage (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        sub_op_i,
  input  logic [2:0]  rm_i,
  input  logic [2:0]  frm_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        sign_a_o,
  output logic        sign_b_o,
  output logic [7:0]  exp_a_o,
  output logic [7:0]  exp_b_o,
  output logic [23:0] sig_a_o,
  output logic [23:0] sig_b_o,
  output logic        is_zero_a_o,
  output logic        is_zero_b_o,
  output logic        is_inf_a_o,
  output logic        is_inf_b_o,
  output logic        is_nan_a_o,
  output logic        is_nan_b_o,
  output logic        is_signaling_o,
`ifdef FPU_ADDSUB_DAZ_EN
  output logic        daz_o,
`endif
  output logic        sub_op_o,
  output logic [2:0]  rm_o,
  output logic        illegal_rm_o
);
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
    logic        zero;
    logic        inf;
    logic        nan;
  } op_fields_t;
  typedef struct packed {
    op_fields_t f;
    logic       snan;
`ifdef FPU_ADDSUB_DAZ_EN
    logic       flush;
`endif
  } opnd_t;
  typedef struct packed {
    op_fields_t a;
    op_fields_t b;
    logic       signaling;
    logic       sub_op;
    logic [2:0] rm;
    logic       illegal;
`ifdef FPU_ADDSUB_DAZ_EN
    logic       daz;
`endif
  } fields_t;

  function automatic opnd_t unpack(input logic [31:0] x);
    opnd_t o;
    logic  exp_zero;
    logic  frac_zero;
    exp_zero   = x[30:23] == 8'd0;
    frac_zero  = x[22:0] == 23'd0;
    o.f.sign   = x[31];
    o.f.exp    = x[30:23];
    o.f.sig    = {!exp_zero, x[22:0]};
    o.f.zero   = exp_zero && frac_zero;
    o.f.inf    = (&x[30:23]) && frac_zero;
    o.f.nan    = (&x[30:23]) && !frac_zero;
    o.snan     = o.f.nan && !x[22];
`ifdef FPU_ADDSUB_DAZ_EN
    o.flush    = exp_zero && !frac_zero;
    o.f.sig    = o.flush ? 24'd0 : o.f.sig;
    o.f.zero   = o.f.zero || o.flush;
`endif
    return o;
  endfunction

  state_t  state_q, state_d;
  fields_t main_q, main_d, skid_q, skid_d, in_d;
  opnd_t   ua, ub;
  logic    acc, drain;

  always_comb begin
    ua           = unpack(op_a_i);
    ub           = unpack(op_b_i);
    in_d.a       = ua.f;
    in_d.b       = ub.f;
    in_d.signaling = ua.snan || ub.snan;
    in_d.sub_op  = sub_op_i;
    in_d.rm      = (rm_i == 3'b111) ? frm_i : rm_i;
    in_d.illegal = in_d.rm[2] && (in_d.rm[1] || in_d.rm[0]);
`ifdef FPU_ADDSUB_DAZ_EN
    in_d.daz     = ua.flush || ub.flush;
`endif
  end

  always_comb begin
    valid_o = state_q != EMPTY;
    ready_o = state_q != FULL;
  end

  assign acc   = valid_i && ready_o;
  assign drain = valid_o && ready_i;

  always_comb begin
    state_d = (state_q == EMPTY) ? (acc ? ONE : EMPTY)
            : (state_q == ONE)   ? ((acc && !drain) ? FULL : (drain && !acc) ? EMPTY : ONE)
            : (drain ? ONE : FULL);
  end

  // Skid drains into main first; acc cannot coincide with that since ready_o is low in FULL.
  always_comb begin
    main_d = (state_q == FULL && drain) ? skid_q
           : (acc && (state_q == EMPTY || drain)) ? in_d : main_q;
    skid_d = (acc && state_q == ONE && !drain) ? in_d : skid_q;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign sign_a_o       = main_q.a.sign;
  assign sign_b_o       = main_q.b.sign;
  assign exp_a_o        = main_q.a.exp;
  assign exp_b_o        = main_q.b.exp;
  assign sig_a_o        = main_q.a.sig;
  assign sig_b_o        = main_q.b.sig;
  assign is_zero_a_o    = main_q.a.zero;
  assign is_zero_b_o    = main_q.b.zero;
  assign is_inf_a_o     = main_q.a.inf;
  assign is_inf_b_o     = main_q.b.inf;
  assign is_nan_a_o     = main_q.a.nan;
  assign is_nan_b_o     = main_q.b.nan;
  assign is_signaling_o = main_q.signaling;
  assign sub_op_o       = main_q.sub_op;
  assign rm_o           = main_q.rm;
  assign illegal_rm_o   = main_q.illegal;
`ifdef FPU_ADDSUB_DAZ_EN
  assign daz_o          = main_q.daz;
`endif
endmodule

// File: tb/tb_fpu_addsub_operand_stage.sv
// tb_fpu_addsub_operand_stage: directed checks of unpack, rounding resolve and skid buffering.
module tb_fpu_addsub_operand_stage;
  logic        clk_i = 0, reset_i = 0, valid_i = 0, ready_i = 1, sub_op_i = 0;
  logic [31:0] op_a_i = 0, op_b_i = 0;
  logic [2:0]  rm_i = 0, frm_i = 0;
  logic        ready_o, valid_o, sign_a_o, sign_b_o;
  logic [7:0]  exp_a_o, exp_b_o;
  logic [23:0] sig_a_o, sig_b_o;
  logic        is_zero_a_o, is_zero_b_o, is_inf_a_o, is_inf_b_o, is_nan_a_o, is_nan_b_o;
  logic        is_signaling_o, sub_op_o, illegal_rm_o;
  logic [2:0]  rm_o;
`ifdef FPU_ADDSUB_DAZ_EN
  logic        daz_o;
`endif
  int total = 0, bad = 0;

  fpu_addsub_operand_stage dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .sub_op_i(sub_op_i), .rm_i(rm_i), .frm_i(frm_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .sign_a_o(sign_a_o), .sign_b_o(sign_b_o), .exp_a_o(exp_a_o), .exp_b_o(exp_b_o),
    .sig_a_o(sig_a_o), .sig_b_o(sig_b_o),
    .is_zero_a_o(is_zero_a_o), .is_zero_b_o(is_zero_b_o),
    .is_inf_a_o(is_inf_a_o), .is_inf_b_o(is_inf_b_o),
    .is_nan_a_o(is_nan_a_o), .is_nan_b_o(is_nan_b_o),
    .is_signaling_o(is_signaling_o),
`ifdef FPU_ADDSUB_DAZ_EN
    .daz_o(daz_o),
`endif
    .sub_op_o(sub_op_o), .rm_o(rm_o), .illegal_rm_o(illegal_rm_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [2:0] rm, input logic [2:0] frm);
    valid_i = 1; op_a_i = a; op_b_i = b; sub_op_i = s; rm_i = rm; frm_i = frm;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [2:0] rm, input logic [2:0] frm);
    drive(a, b, s, rm, frm);
    @(negedge clk_i);
    valid_i = 0;
  endtask

  initial begin
    #12;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_exp_a", exp_a_o, 0);
    chk("rst_sig_b", sig_b_o, 0);
    chk("rst_rm", rm_o, 0);
    @(negedge clk_i); reset_i = 1;
    @(negedge clk_i);
    send(32'h3F800000, 32'h40000000, 0, 3'b000, 3'b000);
    chk("t1_valid", valid_o, 1);
    chk("t1_sig_a", sig_a_o, 24'h800000);
    chk("t1_exp_a", exp_a_o, 8'h7F);
    chk("t1_exp_b", exp_b_o, 8'h80);
    chk("t1_sig_b", sig_b_o, 24'h800000);
    chk("t1_rm", rm_o, 3'b000);
    chk("t1_sign_a", sign_a_o, 0);
    @(negedge clk_i);
    chk("t1_drained", valid_o, 0);
    send(32'h7F800001, 32'hFF800000, 0, 3'b000, 3'b000);
    chk("cls_nan_a", is_nan_a_o, 1);
    chk("cls_sig", is_signaling_o, 1);
    chk("cls_inf_b", is_inf_b_o, 1);
    chk("cls_sign_b", sign_b_o, 1);
    chk("cls_nan_b", is_nan_b_o, 0);
    chk("cls_sig_a", sig_a_o, 24'h800001);
    send(32'h7FC00000, 32'hFF800000, 1, 3'b000, 3'b000);
    chk("qnan_sig", is_signaling_o, 0);
    chk("qnan_nan_a", is_nan_a_o, 1);
    chk("qnan_sig_a", sig_a_o, 24'hC00000);
    chk("sub_op", sub_op_o, 1);
    send(32'h80000000, 32'h00000000, 0, 3'b111, 3'b010);
    chk("zero_a", is_zero_a_o, 1);
    chk("zero_sign_a", sign_a_o, 1);
    chk("zero_sig_a", sig_a_o, 0);
    chk("zero_b", is_zero_b_o, 1);
    chk("dyn_rm_010", rm_o, 3'b010);
    chk("dyn_ill_010", illegal_rm_o, 0);
    send(32'h3F800000, 32'h3F800000, 0, 3'b111, 3'b101);
    chk("dyn_rm_101", rm_o, 3'b101);
    chk("dyn_ill_101", illegal_rm_o, 1);
    chk("norm_zero_a", is_zero_a_o, 0);
    send(32'h3F800000, 32'h3F800000, 0, 3'b110, 3'b000);
    chk("st_rm_110", rm_o, 3'b110);
    chk("st_ill_110", illegal_rm_o, 1);
    send(32'h3F800000, 32'h3F800000, 0, 3'b011, 3'b111);
    chk("st_rm_011", rm_o, 3'b011);
    chk("st_ill_011", illegal_rm_o, 0);
    @(negedge clk_i);
    // backpressure: T0 main, T1 skid, T2 held off
    ready_i = 0;
    drive(32'h3F800000, 0, 0, 3'b000, 3'b000);
    @(negedge clk_i);
    chk("bp_t0_valid", valid_o, 1);
    chk("bp_t0_ready", ready_o, 1);
    chk("bp_t0_exp", exp_a_o, 8'h7F);
    drive(32'h40000000, 0, 0, 3'b000, 3'b000);
    @(negedge clk_i);
    chk("bp_full_ready", ready_o, 0);
    chk("bp_full_exp", exp_a_o, 8'h7F);
    drive(32'h40800000, 0, 0, 3'b000, 3'b000);
    @(negedge clk_i);
    chk("bp_hold_ready", ready_o, 0);
    chk("bp_hold_exp", exp_a_o, 8'h7F);
    chk("bp_hold_valid", valid_o, 1);
    ready_i = 1;
    @(negedge clk_i);
    chk("bp_out_t1", exp_a_o, 8'h80);
    chk("bp_out_t1_ready", ready_o, 1);
    @(negedge clk_i);
    valid_i = 0;
    chk("bp_out_t2", exp_a_o, 8'h81);
    chk("bp_out_t2_valid", valid_o, 1);
    @(negedge clk_i);
    chk("bp_empty", valid_o, 0);
    // reset while FULL
    ready_i = 0;
    send(32'h3F800000, 32'h40000000, 0, 3'b001, 3'b000);
    send(32'h40000000, 32'h40000000, 0, 3'b001, 3'b000);
    chk("mr_full_ready", ready_o, 0);
    #2 reset_i = 0;
    #1;
    chk("mr_valid", valid_o, 0);
    chk("mr_ready", ready_o, 1);
    chk("mr_exp_a", exp_a_o, 0);
    chk("mr_sig_a", sig_a_o, 0);
    chk("mr_rm", rm_o, 0);
    @(negedge clk_i); reset_i = 1; ready_i = 1;
    @(negedge clk_i);
    chk("mr_no_stale0", valid_o, 0);
    @(negedge clk_i);
    chk("mr_no_stale1", valid_o, 0);
    send(32'h00000001, 32'h3F800000, 0, 3'b000, 3'b000);
    chk("sub_exp_a", exp_a_o, 0);
`ifdef FPU_ADDSUB_DAZ_EN
    chk("daz_sig_a", sig_a_o, 0);
    chk("daz_zero_a", is_zero_a_o, 1);
    chk("daz_flag", daz_o, 1);
    send(32'h3F800000, 32'h3F800000, 0, 3'b000, 3'b000);
    chk("daz_clear", daz_o, 0);
`else
    chk("sub_sig_a", sig_a_o, 24'h000001);
    chk("sub_zero_a", is_zero_a_o, 0);
`endif
    @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_addsub_operand_stage.md
Name: fpu_addsub_operand_stage

Overview:
- Registered operand-unpack stage directly upstream of the single-precision FP add/sub datapath.
- Accepts two raw IEEE-754 binary32 operands plus the op and rounding controls over a valid/ready handshake.
- Resolves dynamic rounding mode and splits each operand into sign, exponent, and 24-bit significand with implicit bit.
- Classifies zero/inf/NaN/signaling and presents all fields from registers to the add/sub datapath, with a 2-entry skid buffer so backpressure never drops a transaction.

Parameters:
- None. Width is fixed at binary32.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-low reset
- valid_i  in  1  upstream operand pair valid
- ready_o  out  1  stage can accept
- op_a_i  in  32  raw operand A
- op_b_i  in  32  raw operand B
- sub_op_i  in  1  1 = A-B, 0 = A+B
- rm_i  in  3  instruction rounding mode; 3'b111 = dynamic
- frm_i  in  3  fcsr.frm, sampled with the transaction
- valid_o  out  1  downstream fields valid
- ready_i  in  1  downstream accepts
- sign_a_o, sign_b_o  out  1  operand signs
- exp_a_o, exp_b_o  out  8  raw biased exponents
- sig_a_o, sig_b_o  out  24  {implicit bit, fraction}
- is_zero_a_o, is_zero_b_o  out  1  operand is ±0
- is_inf_a_o, is_inf_b_o  out  1  operand is ±inf
- is_nan_a_o, is_nan_b_o  out  1  operand is NaN
- is_signaling_o  out  1  A or B is sNaN
- sub_op_o  out  1  registered sub_op
- rm_o  out  3  resolved rounding mode
- illegal_rm_o  out  1  resolved mode is 101, 110 or 111

Behaviour:
- Reset (reset_i low, async): all entries invalid; valid_o=0; ready_o=1; every data output 0.
- Reset asserted mid-transfer discards both entries with no output pulse. Release is synchronous to clk_i.
- Storage: main register (drives outputs) plus skid register.
- ready_o = !skid_valid, driven from a register with no combinational path from ready_i.
- Accept: valid_i && ready_o at the rising edge.
  - Main empty, or main draining (valid_o && ready_i): accepted data loads main.
  - Otherwise: accepted data loads skid.
- Drain: valid_o && ready_i with skid valid moves skid into main the same edge. A simultaneous accept is impossible in this case because ready_o=0.
- Latency: 1 cycle from accept to valid_o when empty. Throughput: 1 per cycle while ready_i=1.
- States (valid bits): EMPTY(0,0), ONE(1,0), FULL(1,1).
  - EMPTY -acc-> ONE
  - ONE -acc&!drain-> FULL
  - ONE -drain&!acc-> EMPTY
  - ONE -acc&drain-> ONE
  - FULL -drain-> ONE
- Outputs stay stable while valid_o && !ready_i.
- Decode, computed before the register so outputs are pure flops:
  - sig = {exp!=0, frac[22:0]}.
  - is_zero = exp==0 && frac==0.
  - is_inf = exp==255 && frac==0.
  - is_nan = exp==255 && frac!=0.
  - sNaN = is_nan && frac[22]==0.
  - is_signaling_o = sNaN(A) | sNaN(B).
- Rounding mode:
  - rm_o = (rm_i==3'b111) ? frm_i : rm_i, using frm_i captured at accept.
  - illegal_rm_o = rm_o is 101, 110 or 111.
  - The transaction still passes through; the decode/trap logic uses the flag.
- Subnormals (exp 0, frac≠0): exp_o=0, implicit bit 0, no zero flag. The datapath itself treats exponent 0 as 1.

Optional Feature:
- Macro: FPU_ADDSUB_DAZ_EN.
- When defined (denormals-are-zero): a subnormal input is captured as signed zero, i.e. sign kept, exp=0, sig=0, is_zero=1.
  - Adds output daz_o (1 bit): set when either operand was flushed, registered alongside the data and reset to 0.
- When undefined: subnormals pass unchanged and daz_o does not exist.

Test Plan:
- Reset then single transfer: op_a=32'h3F800000, op_b=32'h40000000, rm_i=000, ready_i=1 -> next cycle valid_o=1, sig_a=24'h800000, exp_a=8'h7F, exp_b=8'h80, sig_b=24'h800000, rm_o=000.
- Classification: op_a=32'h7F800001, op_b=32'hFF800000 -> is_nan_a=1, is_signaling_o=1, is_inf_b=1, sign_b=1. Then op_a=32'h7FC00000 -> is_signaling_o=0.
- Dynamic rm: rm_i=111 with frm_i=010 -> rm_o=010, illegal_rm_o=0. rm_i=111 with frm_i=101 -> rm_o=101, illegal_rm_o=1.
- Backpressure: hold ready_i=0, drive 3 back-to-back valid_i transactions T0–T2 -> T0 in main, T1 in skid, ready_o=0 for T2. Raise ready_i -> outputs T0, T1, then T2 in order with no loss or duplication.
- Reset mid-operation: FULL state, pull reset_i low for 1 cycle -> valid_o=0 immediately (async), ready_o=1, all data 0. No stale transaction after release.
- Subnormal: op_a=32'h00000001 -> without DAZ: sig_a=24'h000001, is_zero_a=0. With FPU_ADDSUB_DAZ_EN: sig_a=0, is_zero_a=1, daz_o=1.
